stopwatch_lap: RTL

Parametrised successor of the board stopwatch: a 00:00.00–59:59.99 centisecond timer with synchronous BCD cascade counting and on-chip key debouncing. Adds a lap/split buffer of LAP_DEPTH entries, recall of stored laps while stopped, and a sticky overflow flag. Outputs packed BCD digits; the existing sevenseg decoders instantiated at top level drive hex0..hex5.

---
 rtl/stopwatch_pkg.sv | 12 +
 rtl/key_debounce.sv | 33 +++
 rtl/stopwatch_lap.sv | 95 +++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared BCD time types, digit limits and timer state for the lap stopwatch.
package stopwatch_pkg;
  typedef logic [3:0] bcd_t;
  typedef bcd_t [5:0] time_t;
  localparam bcd_t UNIT_MAX = 4'd9;
  localparam bcd_t TENS_MAX = 4'd5;
  localparam int TICK_10MS = 500000;
  typedef enum logic {STOPPED, RUNNING} state_t;
  function automatic bcd_t digit_max(input int i);
    return (i == 3 || i == 5) ? TENS_MAX : UNIT_MAX;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises an active-low key and emits one pulse per accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  logic s1, s2, level;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      level <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      press <= 1'b0;
      if (s2 == level) cnt <= '0;
      else if (cnt == CNT_MAX) begin
        level <= s2;
        cnt <= '0;
        press <= !s2;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: 59:59.99 BCD stopwatch with debounced keys, lap buffer, recall and sticky overflow.
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_10MS,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LAP_DEPTH = 8,
  localparam int LAP_AW = $clog2(LAP_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_start_pause_n,
  input  logic              key_lap_n,
  input  logic              key_clear_n,
  output logic [23:0]       disp_bcd,
  output logic              running,
  output logic              recall_mode,
  output logic [LAP_AW-1:0] lap_index,
  output logic [LAP_AW:0]   lap_count,
  output logic              lap_full,
  output logic              overflow
);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [LAP_AW:0] LAP_MAX = (LAP_AW + 1)'(LAP_DEPTH);
  logic p_sp, p_lap, p_clr, lp, cp, tick, carry, wrap;
  logic [PW-1:0] pre;
  logic [LAP_AW-1:0] wr_ptr;
  logic [LAP_AW:0] idx_inc;
  logic [5:0] at_max;
  state_t state;
  time_t tm, nxt;
  time_t laps [LAP_DEPTH];
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sp (.clk, .reset, .key_n(key_start_pause_n), .press(p_sp));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (.clk, .reset, .key_n(key_lap_n), .press(p_lap));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (.clk, .reset, .key_n(key_clear_n), .press(p_clr));
  assign running = state == RUNNING;
  assign tick = running && pre == PRE_MAX;
  assign lap_full = lap_count == LAP_MAX;
  assign idx_inc = {1'b0, lap_index} + 1'b1;
  assign lp = p_lap && !p_sp;
  assign cp = p_clr && !p_sp && !p_lap;
  always_comb begin
    nxt = tm;
    at_max = '0;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      at_max[i] = tm[i] == digit_max(i);
      nxt[i] = !carry ? tm[i] : at_max[i] ? '0 : tm[i] + 1'b1;
      carry = carry && at_max[i];
    end
    wrap = carry;
  end
  // tm is only written on tick, clear or reset, so it holds while stopped
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STOPPED;
      pre <= '0;
      tm <= '0;
      wr_ptr <= '0;
      lap_count <= '0;
      lap_index <= '0;
      recall_mode <= 1'b0;
      overflow <= 1'b0;
      disp_bcd <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) laps[i] <= '0;
    end else begin
      if (running) pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        tm <= nxt;
        overflow <= overflow | wrap;
      end
      if (p_sp) begin
        state <= running ? STOPPED : RUNNING;
        recall_mode <= 1'b0;
      end else if (lp && running && !lap_full) begin
        laps[wr_ptr] <= tm;
        wr_ptr <= wr_ptr + 1'b1;
        lap_count <= lap_count + 1'b1;
      end else if (lp && !running && lap_count != '0) begin
        recall_mode <= 1'b1;
        lap_index <= (!recall_mode || idx_inc == lap_count) ? '0 : idx_inc[LAP_AW-1:0];
      end else if (cp && !running) begin
        tm <= '0;
        pre <= '0;
        wr_ptr <= '0;
        lap_count <= '0;
        lap_index <= '0;
        overflow <= 1'b0;
        recall_mode <= 1'b0;
      end
      disp_bcd <= recall_mode ? laps[lap_index] : tm;
    end
  end
endmodule
